// File: rtl/iob_axi2ibex_mem_pkg.sv
// Shared types and encodings for the AXI4 to Ibex memory-port bridge.
package iob_axi2ibex_mem_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_DATA,
    S_WR_REQ,
    S_WR_WAIT,
    S_WR_RESP,
    S_RD_REQ,
    S_RD_WAIT,
    S_RD_RESP
  } state_t;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/iob_axi_burst_addr.sv
// Next beat address: FIXED bursts stay put, every other burst type steps one word.
module iob_axi_burst_addr
  import iob_axi2ibex_mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr
);

  // WRAP and the reserved encoding are treated as INCR; the add wraps naturally.
  assign next_addr = (burst == BURST_FIXED) ? addr : addr + ADDR_W'(4);

endmodule

// File: rtl/iob_axi2ibex_mem.sv
// AXI4 subordinate that splits read/write bursts into single-beat Ibex memory-port accesses.
module iob_axi2ibex_mem
  import iob_axi2ibex_mem_pkg::*;
#(
  parameter int AXI_ID_W   = 1,
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int AXI_LEN_W  = 8
) (
  input  logic                    clk_i,
  input  logic                    cke_i,
  input  logic                    arst_i,

  input  logic                    axi_awvalid_i,
  output logic                    axi_awready_o,
  input  logic [AXI_ADDR_W-1:0]   axi_awaddr_i,
  input  logic [AXI_ID_W-1:0]     axi_awid_i,
  input  logic [AXI_LEN_W-1:0]    axi_awlen_i,
  input  logic [1:0]              axi_awburst_i,

  input  logic                    axi_wvalid_i,
  output logic                    axi_wready_o,
  input  logic [AXI_DATA_W-1:0]   axi_wdata_i,
  input  logic [AXI_DATA_W/8-1:0] axi_wstrb_i,
  input  logic                    axi_wlast_i,

  output logic                    axi_bvalid_o,
  input  logic                    axi_bready_i,
  output logic [1:0]              axi_bresp_o,
  output logic [AXI_ID_W-1:0]     axi_bid_o,

  input  logic                    axi_arvalid_i,
  output logic                    axi_arready_o,
  input  logic [AXI_ADDR_W-1:0]   axi_araddr_i,
  input  logic [AXI_ID_W-1:0]     axi_arid_i,
  input  logic [AXI_LEN_W-1:0]    axi_arlen_i,
  input  logic [1:0]              axi_arburst_i,

  output logic                    axi_rvalid_o,
  input  logic                    axi_rready_i,
  output logic [AXI_DATA_W-1:0]   axi_rdata_o,
  output logic [1:0]              axi_rresp_o,
  output logic [AXI_ID_W-1:0]     axi_rid_o,
  output logic                    axi_rlast_o,

  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [AXI_DATA_W/8-1:0] mem_be_o,
  output logic [AXI_ADDR_W-3:0]   mem_addr_o,
  output logic [AXI_DATA_W-1:0]   mem_wdata_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [AXI_DATA_W-1:0]   mem_rdata_i,
  input  logic                    mem_err_i
);

  localparam int STRB_W = AXI_DATA_W / 8;

  state_t                  state, state_next;
  logic [AXI_ID_W-1:0]     id_r;
  logic [AXI_ADDR_W-1:0]   addr_r;
  logic [AXI_ADDR_W-1:0]   addr_next;
  logic [AXI_LEN_W-1:0]    len_r;
  logic [AXI_LEN_W-1:0]    beat_r;
  logic [1:0]              burst_r;
  logic                    err_r;
  logic                    prio_wr;
  logic [STRB_W-1:0]       be_r;
  logic [AXI_DATA_W-1:0]   wdata_r;
  logic [AXI_DATA_W-1:0]   rdata_r;
  logic [1:0]              rresp_r;
  logic                    rlast_r;
  logic                    last_beat;
  logic                    unused_ok;

  assign last_beat = (beat_r == len_r);
  assign unused_ok = ^{axi_wlast_i, addr_r[1:0]};

  iob_axi_burst_addr #(.ADDR_W(AXI_ADDR_W)) u_burst_addr (
    .addr      (addr_r),
    .burst     (burst_r),
    .next_addr (addr_next)
  );

  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      state <= S_IDLE;
    end else if (cke_i) begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    axi_awready_o = 1'b0;
    axi_arready_o = 1'b0;
    axi_wready_o  = 1'b0;
    axi_bvalid_o  = 1'b0;
    axi_rvalid_o  = 1'b0;
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    case (state)
      S_IDLE: begin
        // prio_wr means the write channel wins a tie; it flips after each grant.
        if (axi_awvalid_i && (!axi_arvalid_i || prio_wr)) begin
          axi_awready_o = 1'b1;
          state_next    = S_WR_DATA;
        end else if (axi_arvalid_i) begin
          axi_arready_o = 1'b1;
          state_next    = S_RD_REQ;
        end
      end
      S_WR_DATA: begin
        axi_wready_o = 1'b1;
        if (axi_wvalid_i) state_next = S_WR_REQ;
      end
      S_WR_REQ: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        if (mem_gnt_i) state_next = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        if (mem_rvalid_i) state_next = last_beat ? S_WR_RESP : S_WR_DATA;
      end
      S_WR_RESP: begin
        axi_bvalid_o = 1'b1;
        if (axi_bready_i) state_next = S_IDLE;
      end
      S_RD_REQ: begin
        mem_req_o = 1'b1;
        if (mem_gnt_i) state_next = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (mem_rvalid_i) state_next = S_RD_RESP;
      end
      S_RD_RESP: begin
        axi_rvalid_o = 1'b1;
        if (axi_rready_i) state_next = rlast_r ? S_IDLE : S_RD_REQ;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      id_r    <= '0;
      addr_r  <= '0;
      len_r   <= '0;
      beat_r  <= '0;
      burst_r <= BURST_FIXED;
      err_r   <= 1'b0;
      prio_wr <= 1'b1;
      be_r    <= '0;
      wdata_r <= '0;
      rdata_r <= '0;
      rresp_r <= RESP_OKAY;
      rlast_r <= 1'b0;
    end else if (cke_i) begin
      case (state)
        S_IDLE: begin
          if (axi_awvalid_i && axi_awready_o) begin
            id_r    <= axi_awid_i;
            addr_r  <= axi_awaddr_i;
            len_r   <= axi_awlen_i;
            burst_r <= axi_awburst_i;
            beat_r  <= '0;
            err_r   <= 1'b0;
            prio_wr <= 1'b0;
          end else if (axi_arvalid_i && axi_arready_o) begin
            id_r    <= axi_arid_i;
            addr_r  <= axi_araddr_i;
            len_r   <= axi_arlen_i;
            burst_r <= axi_arburst_i;
            beat_r  <= '0;
            err_r   <= 1'b0;
            prio_wr <= 1'b1;
            be_r    <= '1;
          end
        end
        S_WR_DATA: begin
          if (axi_wvalid_i) begin
            wdata_r <= axi_wdata_i;
            be_r    <= axi_wstrb_i;
          end
        end
        S_WR_WAIT: begin
          if (mem_rvalid_i) begin
            err_r <= err_r | mem_err_i;
            if (!last_beat) begin
              beat_r <= beat_r + AXI_LEN_W'(1);
              addr_r <= addr_next;
            end
          end
        end
        S_RD_WAIT: begin
          if (mem_rvalid_i) begin
            rdata_r <= mem_rdata_i;
            rresp_r <= mem_err_i ? RESP_SLVERR : RESP_OKAY;
            rlast_r <= last_beat;
          end
        end
        S_RD_RESP: begin
          // Reads always use all byte lanes, so be_r is reasserted for each new beat.
          if (axi_rready_i && !rlast_r) begin
            beat_r <= beat_r + AXI_LEN_W'(1);
            addr_r <= addr_next;
            be_r   <= '1;
          end
        end
        default: ;
      endcase
    end
  end

  assign axi_bresp_o = err_r ? RESP_SLVERR : RESP_OKAY;
  assign axi_bid_o   = id_r;
  assign axi_rdata_o = rdata_r;
  assign axi_rresp_o = rresp_r;
  assign axi_rid_o   = id_r;
  assign axi_rlast_o = rlast_r;
  assign mem_be_o    = be_r;
  assign mem_addr_o  = addr_r[AXI_ADDR_W-1:2];
  assign mem_wdata_o = wdata_r;

endmodule

// File: tb/tb_iob_axi2ibex_mem.sv
// Directed bench for iob_axi2ibex_mem: reads, write bursts, arbitration, backpressure, reset.
module tb_iob_axi2ibex_mem;

  logic        clk = 1'b0;
  logic        cke = 1'b1;
  logic        rst = 1'b1;
  logic        awvalid = 0, awready;
  logic [31:0] awaddr = 0;
  logic [0:0]  awid = 0;
  logic [7:0]  awlen = 0;
  logic [1:0]  awburst = 0;
  logic        wvalid = 0, wready, wlast = 0;
  logic [31:0] wdata = 0;
  logic [3:0]  wstrb = 0;
  logic        bvalid, bready = 0;
  logic [1:0]  bresp;
  logic [0:0]  bid;
  logic        arvalid = 0, arready;
  logic [31:0] araddr = 0;
  logic [0:0]  arid = 0;
  logic [7:0]  arlen = 0;
  logic [1:0]  arburst = 0;
  logic        rvalid, rready = 0, rlast;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic [0:0]  rid;
  logic        mem_req, mem_we, mem_gnt = 0, mem_rvalid = 0, mem_err = 0;
  logic [3:0]  mem_be;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata = 0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  iob_axi2ibex_mem dut (
    .clk_i(clk), .cke_i(cke), .arst_i(rst),
    .axi_awvalid_i(awvalid), .axi_awready_o(awready), .axi_awaddr_i(awaddr),
    .axi_awid_i(awid), .axi_awlen_i(awlen), .axi_awburst_i(awburst),
    .axi_wvalid_i(wvalid), .axi_wready_o(wready), .axi_wdata_i(wdata),
    .axi_wstrb_i(wstrb), .axi_wlast_i(wlast),
    .axi_bvalid_o(bvalid), .axi_bready_i(bready), .axi_bresp_o(bresp), .axi_bid_o(bid),
    .axi_arvalid_i(arvalid), .axi_arready_o(arready), .axi_araddr_i(araddr),
    .axi_arid_i(arid), .axi_arlen_i(arlen), .axi_arburst_i(arburst),
    .axi_rvalid_o(rvalid), .axi_rready_i(rready), .axi_rdata_o(rdata),
    .axi_rresp_o(rresp), .axi_rid_o(rid), .axi_rlast_o(rlast),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
    .mem_rdata_i(mem_rdata), .mem_err_i(mem_err)
  );

  // Advance one clock and settle 1 ns past the edge before driving/sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    checks++;
    if ({awready, arready, wready, bvalid, rvalid, mem_req, mem_we} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0000000",
               {awready, arready, wready, bvalid, rvalid, mem_req, mem_we});
    end
    checks++;
    if ({bresp, rresp, rlast, bid, rid} !== 7'b0) begin
      failures++;
      $display("FAIL reset_resp got=%b exp=0000000", {bresp, rresp, rlast, bid, rid});
    end
    checks++;
    if ({rdata, mem_be, mem_addr, mem_wdata} !== 98'b0) begin
      failures++;
      $display("FAIL reset_data rdata=%h be=%h addr=%h wdata=%h exp=all zero",
               rdata, mem_be, mem_addr, mem_wdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    arvalid = 1; araddr = 32'h10; arid = 1; arlen = 0; arburst = 2'b01;
    #1;
    checks++;
    if (arready !== 1'b1) begin failures++; $display("FAIL rd1_arready got=%b exp=1", arready); end
    step();
    // Response in the grant cycle must be ignored.
    arvalid = 0; mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'hBAD0BAD0;
    #1;
    checks++;
    if ({mem_req, mem_we, mem_be, mem_addr} !== {1'b1, 1'b0, 4'hF, 30'h4}) begin
      failures++;
      $display("FAIL rd1_req req=%b we=%b be=%h addr=%h exp req=1 we=0 be=f addr=4",
               mem_req, mem_we, mem_be, mem_addr);
    end
    step();
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
    #1;
    checks++;
    if ({rvalid, mem_req} !== 2'b00) begin
      failures++; $display("FAIL rd1_wait rvalid=%b req=%b exp 0 0", rvalid, mem_req);
    end
    step();
    mem_rvalid = 0; mem_rdata = 0; rready = 1;
    #1;
    checks++;
    if ({rvalid, rdata, rresp, rlast, rid} !== {1'b1, 32'hDEADBEEF, 2'b00, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL rd1_r rvalid=%b rdata=%h rresp=%b rlast=%b rid=%b exp 1 deadbeef 00 1 1",
               rvalid, rdata, rresp, rlast, rid);
    end
    step();
    rready = 0;
    #1;
    checks++;
    if ({rvalid, mem_req, arready} !== 3'b000) begin
      failures++; $display("FAIL rd1_idle rvalid=%b req=%b arready=%b exp 000", rvalid, mem_req, arready);
    end
  endtask

  task automatic test_write_burst();
    logic [3:0] strb_tab [4];
    int bcount;
    strb_tab[0] = 4'hF; strb_tab[1] = 4'hF; strb_tab[2] = 4'b0011; strb_tab[3] = 4'hF;
    awvalid = 1; awaddr = 32'h100; awid = 0; awlen = 3; awburst = 2'b01;
    #1;
    checks++;
    if (awready !== 1'b1) begin failures++; $display("FAIL wr_awready got=%b exp=1", awready); end
    step();
    awvalid = 0;
    for (int b = 0; b < 4; b++) begin
      wvalid = 1; wdata = 32'hA000_0000 + 32'(b); wstrb = strb_tab[b];
      #1;
      checks++;
      if ({wready, mem_req} !== 2'b10) begin
        failures++; $display("FAIL wr_wready beat=%0d wready=%b req=%b exp 1 0", b, wready, mem_req);
      end
      step();
      wvalid = 0; wdata = 0; wstrb = 0; mem_gnt = 1;
      #1;
      checks++;
      if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !==
          {1'b1, 1'b1, strb_tab[b], 30'h40 + 30'(b), 32'hA000_0000 + 32'(b)}) begin
        failures++;
        $display("FAIL wr_req beat=%0d req=%b we=%b be=%h addr=%h wdata=%h exp be=%h addr=%h",
                 b, mem_req, mem_we, mem_be, mem_addr, mem_wdata, strb_tab[b], 30'h40 + 30'(b));
      end
      step();
      mem_gnt = 0; mem_rvalid = 1;
      #1;
      checks++;
      if ({bvalid, mem_req} !== 2'b00) begin
        failures++; $display("FAIL wr_wait beat=%0d bvalid=%b req=%b exp 0 0", b, bvalid, mem_req);
      end
      step();
      mem_rvalid = 0;
    end
    bready = 1;
    #1;
    checks++;
    if ({bvalid, bresp, bid} !== {1'b1, 2'b00, 1'b0}) begin
      failures++; $display("FAIL wr_b bvalid=%b bresp=%b bid=%b exp 1 00 0", bvalid, bresp, bid);
    end
    bcount = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (bvalid) bcount++;
    end
    bready = 0;
    checks++;
    if (bcount !== 0) begin failures++; $display("FAIL wr_extra_b got=%0d exp=0", bcount); end
  endtask

  task automatic test_fixed_read_err();
    arvalid = 1; araddr = 32'h200; arid = 0; arlen = 1; arburst = 2'b00;
    #1;
    checks++;
    if (arready !== 1'b1) begin failures++; $display("FAIL fx_arready got=%b exp=1", arready); end
    step();
    arvalid = 0;
    for (int b = 0; b < 2; b++) begin
      mem_gnt = 1;
      #1;
      checks++;
      if ({mem_req, mem_be, mem_addr} !== {1'b1, 4'hF, 30'h80}) begin
        failures++;
        $display("FAIL fx_req beat=%0d req=%b be=%h addr=%h exp 1 f 80", b, mem_req, mem_be, mem_addr);
      end
      step();
      mem_gnt = 0; mem_rvalid = 1; mem_err = (b == 0); mem_rdata = 32'h1000 + 32'(b);
      step();
      mem_rvalid = 0; mem_err = 0; rready = 1;
      #1;
      checks++;
      if ({rvalid, rdata, rresp, rlast} !==
          {1'b1, 32'h1000 + 32'(b), (b == 0) ? 2'b10 : 2'b00, (b == 1) ? 1'b1 : 1'b0}) begin
        failures++;
        $display("FAIL fx_r beat=%0d rvalid=%b rdata=%h rresp=%b rlast=%b", b, rvalid, rdata, rresp, rlast);
      end
      step();
      rready = 0;
    end
    #1;
    checks++;
    if ({rvalid, mem_req} !== 2'b00) begin
      failures++; $display("FAIL fx_done rvalid=%b req=%b exp 0 0", rvalid, mem_req);
    end
  endtask

  task automatic test_arbitration();
    awvalid = 1; awaddr = 32'h300; awid = 1; awlen = 0; awburst = 2'b01;
    arvalid = 1; araddr = 32'h400; arid = 0; arlen = 0; arburst = 2'b01;
    #1;
    checks++;
    if ({awready, arready} !== 2'b10) begin
      failures++; $display("FAIL arb_first aw=%b ar=%b exp 1 0", awready, arready);
    end
    step();
    awvalid = 0; wvalid = 1; wdata = 32'h55; wstrb = 4'hF;
    step();
    wvalid = 0; mem_gnt = 1;
    step();
    mem_gnt = 0; mem_rvalid = 1;
    step();
    mem_rvalid = 0; bready = 1;
    #1;
    checks++;
    if ({bvalid, bid} !== 2'b11) begin
      failures++; $display("FAIL arb_b bvalid=%b bid=%b exp 1 1", bvalid, bid);
    end
    step();
    bready = 0; awvalid = 1; awaddr = 32'h500;
    #1;
    checks++;
    if ({awready, arready} !== 2'b01) begin
      failures++; $display("FAIL arb_second aw=%b ar=%b exp 0 1", awready, arready);
    end
    step();
    awvalid = 0; arvalid = 0; mem_gnt = 1;
    #1;
    checks++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 30'h100}) begin
      failures++; $display("FAIL arb_rd_req req=%b we=%b addr=%h exp 1 0 100", mem_req, mem_we, mem_addr);
    end
    step();
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h77;
    step();
    mem_rvalid = 0; rready = 1;
    step();
    rready = 0;
  endtask

  task automatic test_backpressure();
    int reqs;
    arvalid = 1; araddr = 32'h30; arid = 1; arlen = 0; arburst = 2'b01;
    step();
    arvalid = 0; mem_gnt = 0;
    reqs = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (mem_req && mem_addr === 30'hC) reqs++;
      step();
    end
    checks++;
    if (reqs !== 5) begin failures++; $display("FAIL bp_req_held got=%0d exp=5", reqs); end
    mem_gnt = 1;
    step();
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h12345678;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin failures++; $display("FAIL bp_dup_req got=%b exp=0", mem_req); end
    step();
    mem_rvalid = 0; mem_rdata = 32'hFFFF_FFFF;
    reqs = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (rvalid && rdata === 32'h12345678 && rlast && rid === 1'b1 && !mem_req) reqs++;
      step();
    end
    checks++;
    if (reqs !== 4) begin failures++; $display("FAIL bp_r_held got=%0d exp=4", reqs); end
    rready = 1;
    step();
    rready = 0;
    #1;
    checks++;
    if (rvalid !== 1'b0) begin failures++; $display("FAIL bp_r_done got=%b exp=0", rvalid); end
  endtask

  task automatic test_reset_mid_read();
    int seen;
    arvalid = 1; araddr = 32'h40; arid = 1; arlen = 0; arburst = 2'b01;
    step();
    arvalid = 0; mem_gnt = 1;
    step();
    mem_gnt = 0; rst = 1;
    step();
    rst = 0; mem_rvalid = 1; mem_rdata = 32'hBADBAD00;
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (rvalid || mem_req) seen++;
      step();
    end
    mem_rvalid = 0;
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL rst_stray got=%0d exp=0", seen); end
    arvalid = 1; araddr = 32'h40; arid = 0;
    step();
    arvalid = 0; mem_gnt = 1;
    #1;
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 30'h10}) begin
      failures++; $display("FAIL rst_req req=%b addr=%h exp 1 10", mem_req, mem_addr);
    end
    step();
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hCAFEF00D;
    step();
    mem_rvalid = 0; rready = 1;
    #1;
    checks++;
    if ({rvalid, rdata, rresp, rlast, rid} !== {1'b1, 32'hCAFEF00D, 2'b00, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL rst_r rvalid=%b rdata=%h rresp=%b rlast=%b rid=%b exp 1 cafef00d 00 1 0",
               rvalid, rdata, rresp, rlast, rid);
    end
    step();
    rready = 0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_burst();
    test_fixed_read_err();
    test_arbitration();
    test_backpressure();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
